dds_sweep_ctrl: RTL and testbench
=================================

DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

Interface
REQ-001 SHALL have parameter DEFAULT_FREQ, 32'd42949, frequency control word loaded at reset.
REQ-002 SHALL have parameter DEFAULT_PHASE, 12'd1024, phase offset word loaded at reset.
REQ-003 SHALL have parameter DEFAULT_WAVE, 4'b0001, one-hot waveform select loaded at reset (sine).
REQ-004 sys_clk  in  1  sole clock; all logic rising-edge.
REQ-005 sys_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 cmd_valid  in  1  command present.
REQ-007 cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are high on the same edge.
REQ-008 cmd_op  in  3  opcode: 0 SET_FREQ, 1 SET_PHASE, 2 SET_WAVE, 3 SET_STOP, 4 SET_STEP, 5 SET_DWELL, 6 START, 7 ABORT.
REQ-009 cmd_data  in  32  operand; SET_PHASE uses [11:0], SET_WAVE uses [3:0], START uses [0] as loop flag.
REQ-010 freq_ctrl  out  32  live frequency word to the accumulator.
REQ-011 phase_ctrl  out  12  live phase offset.
REQ-012 wave_select  out  4  live one-hot waveform select.
REQ-013 cfg_update  out  1  one-cycle pulse on any live-output change.
REQ-014 busy  out  1  high while a sweep runs.
REQ-015 sweep_done  out  1  one-cycle pulse when a non-looping sweep reaches stop.
REQ-016 cmd_err  out  1  one-cycle pulse on a rejected command.

Function
REQ-017 FSM states IDLE, APPLY, SWEEP; reset state IDLE.
REQ-018 IDLE: cmd_ready=1; an accepted SET_* writes its shadow register (freq, phase, wave, stop, step, dwell) and moves to APPLY.
REQ-019 APPLY, one cycle: cmd_ready=0; shadow freq/phase/wave copied to live outputs, cfg_update=1, return to IDLE; cmd-to-output latency is 2 edges.
REQ-020 SET_WAVE with a cmd_data[3:0] that is not one-hot: no state change, cmd_err=1, stay IDLE.
REQ-021 START in IDLE with step==0 or stop<=shadow freq (unsigned): cmd_err=1, stay IDLE.
REQ-022 Valid START: freq_ctrl<=shadow freq (start), dwell counter<=0, loop flag latched, cfg_update=1, busy=1, go to SWEEP.
REQ-023 SWEEP: dwell counter increments each cycle; at count==max(dwell,1)-1 it clears and advances the frequency.
REQ-024 Advance: compute 33-bit sum freq_ctrl+step; if sum>=stop, freq_ctrl<=stop, otherwise freq_ctrl<=sum; cfg_update=1 either way.
REQ-025 Reaching stop with loop=0: sweep_done=1 in the same cycle freq_ctrl becomes stop; busy falls on the next edge; go to IDLE.
REQ-026 Reaching stop with loop=1: the next advance reloads freq_ctrl<=start (not start+step); sweep continues; no sweep_done.
REQ-027 SWEEP: cmd_ready=1 only for ABORT. ABORT: freq_ctrl<=shadow freq, cfg_update=1, busy=0, go to IDLE, no sweep_done.
REQ-028 SWEEP: any other opcode is held off (cmd_ready=0) and is not lost.
REQ-029 phase_ctrl and wave_select stay constant during SWEEP.
REQ-030 cfg_update, sweep_done and cmd_err are single-cycle pulses and are never held high.

Reset
REQ-031 Asserting sys_rst_n low at any time, including mid-sweep or in APPLY, SHALL immediately set: freq_ctrl=DEFAULT_FREQ, phase_ctrl=DEFAULT_PHASE, wave_select=DEFAULT_WAVE, all shadows to the same defaults, stop=32'hFFFFFFFF, step=0, dwell=0, cmd_ready=0, busy=0, cfg_update=0, sweep_done=0, cmd_err=0, state IDLE.
REQ-032 cmd_ready SHALL rise on the first edge after reset release.

Structure
REQ-033 A shared package SHALL hold the opcode encodings, FSM state encoding, one-hot wave constants (sine 0001, square 0010, triangle 0100, saw 1000) and default parameter values.
REQ-034 One sub-module, dds_sweep_step (dwell counter plus saturating 33-bit add/compare), is natural; the FSM and registers stay in the top.
REQ-035 Outputs SHALL drive the existing DDS core FREQ_CTRL/PHASE_CTRL/wave_select inputs directly, with no extra register stage.

Verification
REQ-036 Reset release -> freq_ctrl=42949, phase_ctrl=1024, wave_select=0001, cmd_ready=1 after one edge.
REQ-037 SET_FREQ 85898 -> cfg_update at edge+2, freq_ctrl=85898; SET_WAVE 0011 -> cmd_err pulse, wave_select unchanged.
REQ-038 freq=1000, stop=1300, step=100, dwell=3, START loop=0 -> freq 1000,1100,1200,1300 each held 3 cycles; sweep_done with 1300; busy low after.
REQ-039 Same setup with stop=1250 -> last value saturates at 1250; with loop=1 -> 1250 followed by 1000, no sweep_done.
REQ-040 ABORT mid-sweep plus SET_PHASE in the same window -> SET_PHASE held off until IDLE; freq_ctrl back to 1000; then phase applied.
REQ-041 Reset asserted mid-sweep, 2 cycles -> all outputs at defaults asynchronously; busy=0; no pulses.

Source files
------------

// File: rtl/dds_sweep_pkg.sv
// rtl/dds_sweep_pkg.sv - shared encodings and defaults for the DDS sweep controller
// Contents: command opcodes, FSM state encoding, one-hot waveform constants,
// reset default values and a one-hot check helper.
package dds_sweep_pkg;

    typedef enum logic [2:0] {
        OP_SET_FREQ  = 3'd0,
        OP_SET_PHASE = 3'd1,
        OP_SET_WAVE  = 3'd2,
        OP_SET_STOP  = 3'd3,
        OP_SET_STEP  = 3'd4,
        OP_SET_DWELL = 3'd5,
        OP_START     = 3'd6,
        OP_ABORT     = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_SWEEP = 2'd2
    } state_e;

    localparam logic [3:0]  WAVE_SINE     = 4'b0001;
    localparam logic [3:0]  WAVE_SQUARE   = 4'b0010;
    localparam logic [3:0]  WAVE_TRIANGLE = 4'b0100;
    localparam logic [3:0]  WAVE_SAW      = 4'b1000;

    localparam logic [31:0] DEF_FREQ  = 32'd42949;
    localparam logic [11:0] DEF_PHASE = 12'd1024;
    localparam logic [3:0]  DEF_WAVE  = WAVE_SINE;
    localparam logic [31:0] DEF_STOP  = 32'hFFFF_FFFF;
    localparam logic [31:0] DEF_STEP  = 32'd0;
    localparam logic [31:0] DEF_DWELL = 32'd0;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    function automatic logic is_onehot4(input logic [3:0] w);
        return (w != 4'd0) && ((w & (w - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/dds_sweep_step.sv
// rtl/dds_sweep_step.sv - dwell counter and saturating frequency step for a sweep
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   run_i           sweep in progress; counter runs only while high
//   clr_i           restart the dwell count (sweep start or abort)
//   dwell_i         cycles per frequency point (0 treated as 1)
//   freq_i          current live frequency word
//   step_i, stop_i  sweep increment and end point
//   adv_o           advance the frequency on this edge
//   next_o          saturated next frequency (min(freq+step, stop))
//   hit_o           freq+step reached or passed stop
module dds_sweep_step (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        run_i,
    input  logic        clr_i,
    input  logic [31:0] dwell_i,
    input  logic [31:0] freq_i,
    input  logic [31:0] step_i,
    input  logic [31:0] stop_i,
    output logic        adv_o,
    output logic [31:0] next_o,
    output logic        hit_o
);

    logic [31:0] cnt_q, cnt_d;
    logic [31:0] last_cnt;
    logic [32:0] sum;

    always_comb begin
        last_cnt = (dwell_i == 32'd0) ? 32'd0 : dwell_i - 32'd1;
        adv_o    = run_i && (cnt_q == last_cnt);

        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 32'd0;
        end else if (run_i) begin
            cnt_d = adv_o ? 32'd0 : cnt_q + 32'd1;
        end

        // One extra bit so a sum past 2^32-1 still compares as >= stop.
        sum    = {1'b0, freq_i} + {1'b0, step_i};
        hit_o  = sum >= {1'b0, stop_i};
        next_o = hit_o ? stop_i : sum[31:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// rtl/dds_sweep_ctrl.sv - command-driven frequency/phase/wave control with linear sweep
// Ports:
//   sys_clk, sys_rst_n       clock, asynchronous active-low reset
//   cmd_valid/cmd_ready      command handshake
//   cmd_op, cmd_data         opcode and operand
//   freq_ctrl, phase_ctrl,   live words driven straight into the DDS core
//   wave_select
//   cfg_update               pulse whenever the live words were rewritten
//   busy                     sweep running (stays high through the sweep_done cycle)
//   sweep_done               pulse when a non-looping sweep lands on stop
//   cmd_err                  pulse on a rejected command
module dds_sweep_ctrl
    import dds_sweep_pkg::*;
#(
    parameter logic [31:0] DEFAULT_FREQ  = DEF_FREQ,
    parameter logic [11:0] DEFAULT_PHASE = DEF_PHASE,
    parameter logic [3:0]  DEFAULT_WAVE  = DEF_WAVE
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [31:0] cmd_data,
    output logic [31:0] freq_ctrl,
    output logic [11:0] phase_ctrl,
    output logic [3:0]  wave_select,
    output logic        cfg_update,
    output logic        busy,
    output logic        sweep_done,
    output logic        cmd_err
);

    state_e      state_q, state_d;
    op_e         op;
    logic        rdy_q;
    logic [31:0] sh_freq_q,  sh_freq_d;
    logic [11:0] sh_phase_q, sh_phase_d;
    logic [3:0]  sh_wave_q,  sh_wave_d;
    logic [31:0] sh_stop_q,  sh_stop_d;
    logic [31:0] sh_step_q,  sh_step_d;
    logic [31:0] sh_dwell_q, sh_dwell_d;
    logic [31:0] freq_q,  freq_d;
    logic [11:0] phase_q, phase_d;
    logic [3:0]  wave_q,  wave_d;
    logic        loop_q,  loop_d;
    logic        cfg_q,   cfg_d;
    logic        done_q,  done_d;
    logic        err_q,   err_d;
    logic        busy_q,  busy_d;
    logic        accept;
    logic        step_clr;
    logic        step_adv;
    logic        step_hit;
    logic [31:0] step_next;

    assign op = op_e'(cmd_op);

    // rdy_q keeps ready low during reset and for the release cycle. During a
    // sweep only ABORT is taken; other commands wait on the bus until IDLE.
    assign cmd_ready = rdy_q && ((state_q == ST_IDLE) ||
                                 ((state_q == ST_SWEEP) && (op == OP_ABORT)));
    assign accept    = cmd_valid && cmd_ready;

    assign freq_ctrl   = freq_q;
    assign phase_ctrl  = phase_q;
    assign wave_select = wave_q;
    assign cfg_update  = cfg_q;
    assign busy        = busy_q;
    assign sweep_done  = done_q;
    assign cmd_err     = err_q;

    dds_sweep_step u_step (
        .clk_i   (sys_clk),
        .rst_ni  (sys_rst_n),
        .run_i   (state_q == ST_SWEEP),
        .clr_i   (step_clr),
        .dwell_i (sh_dwell_q),
        .freq_i  (freq_q),
        .step_i  (sh_step_q),
        .stop_i  (sh_stop_q),
        .adv_o   (step_adv),
        .next_o  (step_next),
        .hit_o   (step_hit)
    );

    always_comb begin
        state_d    = state_q;
        sh_freq_d  = sh_freq_q;
        sh_phase_d = sh_phase_q;
        sh_wave_d  = sh_wave_q;
        sh_stop_d  = sh_stop_q;
        sh_step_d  = sh_step_q;
        sh_dwell_d = sh_dwell_q;
        freq_d     = freq_q;
        phase_d    = phase_q;
        wave_d     = wave_q;
        loop_d     = loop_q;
        cfg_d      = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        step_clr   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (op)
                        OP_SET_FREQ: begin
                            sh_freq_d = cmd_data;
                            state_d   = ST_APPLY;
                        end
                        OP_SET_PHASE: begin
                            sh_phase_d = cmd_data[11:0];
                            state_d    = ST_APPLY;
                        end
                        OP_SET_WAVE: begin
                            if (is_onehot4(cmd_data[3:0])) begin
                                sh_wave_d = cmd_data[3:0];
                                state_d   = ST_APPLY;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        OP_SET_STOP: begin
                            sh_stop_d = cmd_data;
                            state_d   = ST_APPLY;
                        end
                        OP_SET_STEP: begin
                            sh_step_d = cmd_data;
                            state_d   = ST_APPLY;
                        end
                        OP_SET_DWELL: begin
                            sh_dwell_d = cmd_data;
                            state_d    = ST_APPLY;
                        end
                        OP_START: begin
                            // A sweep must move upward by a non-zero step.
                            if ((sh_step_q == 32'd0) || (sh_stop_q <= sh_freq_q)) begin
                                err_d = 1'b1;
                            end else begin
                                freq_d   = sh_freq_q;
                                loop_d   = cmd_data[0];
                                cfg_d    = 1'b1;
                                step_clr = 1'b1;
                                state_d  = ST_SWEEP;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_APPLY: begin
                freq_d  = sh_freq_q;
                phase_d = sh_phase_q;
                wave_d  = sh_wave_q;
                cfg_d   = 1'b1;
                state_d = ST_IDLE;
            end
            ST_SWEEP: begin
                // Abort takes priority over an advance landing on the same edge.
                if (accept) begin
                    freq_d   = sh_freq_q;
                    cfg_d    = 1'b1;
                    step_clr = 1'b1;
                    state_d  = ST_IDLE;
                end else if (step_adv) begin
                    cfg_d = 1'b1;
                    // The sweep only sits exactly on stop after saturating, so
                    // in loop mode that is the cue to restart from the start word.
                    if (loop_q && (freq_q == sh_stop_q)) begin
                        freq_d = sh_freq_q;
                    end else begin
                        freq_d = step_next;
                        if (step_hit && !loop_q) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // busy lingers through the sweep_done cycle and drops on the next edge.
        busy_d = (state_d == ST_SWEEP) || done_d;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= ST_IDLE;
            rdy_q      <= 1'b0;
            sh_freq_q  <= DEFAULT_FREQ;
            sh_phase_q <= DEFAULT_PHASE;
            sh_wave_q  <= DEFAULT_WAVE;
            sh_stop_q  <= DEF_STOP;
            sh_step_q  <= DEF_STEP;
            sh_dwell_q <= DEF_DWELL;
            freq_q     <= DEFAULT_FREQ;
            phase_q    <= DEFAULT_PHASE;
            wave_q     <= DEFAULT_WAVE;
            loop_q     <= 1'b0;
            cfg_q      <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rdy_q      <= 1'b1;
            sh_freq_q  <= sh_freq_d;
            sh_phase_q <= sh_phase_d;
            sh_wave_q  <= sh_wave_d;
            sh_stop_q  <= sh_stop_d;
            sh_step_q  <= sh_step_d;
            sh_dwell_q <= sh_dwell_d;
            freq_q     <= freq_d;
            phase_q    <= phase_d;
            wave_q     <= wave_d;
            loop_q     <= loop_d;
            cfg_q      <= cfg_d;
            done_q     <= done_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb/tb_dds_sweep_ctrl.sv - scoreboard bench for dds_sweep_ctrl
module tb_dds_sweep_ctrl;

    localparam int C_FREQ = 0, C_PHASE = 1, C_WAVE = 2, C_STOP = 3;
    localparam int C_STEP = 4, C_DWELL = 5, C_START = 6, C_ABORT = 7;
    localparam logic [31:0] D_FREQ  = 32'd42949;
    localparam logic [11:0] D_PHASE = 12'd1024;
    localparam logic [3:0]  D_WAVE  = 4'b0001;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = 3'd0;
    logic [31:0] cmd_data = 32'd0;
    logic [31:0] freq_ctrl;
    logic [11:0] phase_ctrl;
    logic [3:0]  wave_select;
    logic        cfg_update, busy, sweep_done, cmd_err;

    dds_sweep_ctrl dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_data    (cmd_data),
        .freq_ctrl   (freq_ctrl),
        .phase_ctrl  (phase_ctrl),
        .wave_select (wave_select),
        .cfg_update  (cfg_update),
        .busy        (busy),
        .sweep_done  (sweep_done),
        .cmd_err     (cmd_err)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [31:0] f;
        logic [11:0] p;
        logic [3:0]  w;
        logic        b;
        logic        d;
        int          gap;
    } exp_t;

    exp_t sb[$];
    int   tests = 0, fails = 0, pops = 0, cyc = 0, last_cfg = 0;
    int   exp_errs = 0, target_g = 0;

    // Reference model: shadow configuration as the host believes it to be.
    logic [31:0] m_freq = D_FREQ, m_stop = 32'hFFFF_FFFF, m_step = 0, m_dwell = 0;
    logic [11:0] m_phase = D_PHASE;
    logic [3:0]  m_wave = D_WAVE;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic flag(input string nm);
        tests++;
        fails++;
        $display("FAIL %s: condition not expected at cycle %0d", nm, cyc);
    endtask

    // Monitor: every cfg_update pops one expected live snapshot.
    always @(negedge sys_clk) begin
        exp_t e;
        cyc++;
        if (sys_rst_n) begin
            if (cfg_update) begin
                if (sb.size() == 0) begin
                    flag("cfg_unexpected");
                end else begin
                    e = sb.pop_front();
                    pops++;
                    chk("cfg_freq",  freq_ctrl,   e.f);
                    chk("cfg_phase", phase_ctrl,  e.p);
                    chk("cfg_wave",  wave_select, e.w);
                    chk("cfg_busy",  busy,        e.b);
                    chk("cfg_done",  sweep_done,  e.d);
                    if (e.gap != 0) chk("dwell_gap", cyc - last_cfg, e.gap);
                end
                last_cfg = cyc;
            end else if (sweep_done) begin
                flag("done_without_cfg");
            end
            if (cmd_err) begin
                if (exp_errs == 0) flag("err_unexpected");
                else exp_errs--;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    task automatic push(input logic [31:0] f, input logic b, input logic d, input int gap);
        exp_t e;
        e.f = f; e.p = m_phase; e.w = m_wave; e.b = b; e.d = d; e.gap = gap;
        sb.push_back(e);
    endtask

    task automatic send(input int op, input logic [31:0] d);
        int n = 0;
        @(negedge sys_clk);
        cmd_valid = 1'b1;
        cmd_op    = 3'(op);
        cmd_data  = d;
        #1;
        while (!cmd_ready && n < 4000) begin
            @(negedge sys_clk); #1; n++;
        end
        if (n >= 4000) flag("send_timeout");
        @(posedge sys_clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_pops(input int target);
        int n = 0;
        while (pops < target && n < 5000) begin
            @(negedge sys_clk); #1; n++;
        end
        if (n >= 5000) flag("wait_pops_timeout");
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 5000) begin
            @(negedge sys_clk); #1; n++;
        end
        if (n >= 5000) flag("drain_timeout");
    endtask

    task automatic m_set(input int op, input logic [31:0] d);
        case (op)
            C_FREQ:  m_freq  = d;
            C_PHASE: m_phase = d[11:0];
            C_STOP:  m_stop  = d;
            C_STEP:  m_step  = d;
            C_DWELL: m_dwell = d;
            default: begin
                if ($countones(d[3:0]) == 1) m_wave = d[3:0];
            end
        endcase
        if (op == C_WAVE && $countones(d[3:0]) != 1) exp_errs++;
        else push(m_freq, 1'b0, 1'b0, 0);
        send(op, d);
    endtask

    // Expected sweep: start, start+step, ... clipped to stop; loop restarts
    // at start after stop. Loop runs are cut after nvals points.
    task automatic m_start(input bit lp, input int nvals);
        longint v, nx;
        int g, k;
        logic dn;
        if (m_step == 0 || m_stop <= m_freq) begin
            exp_errs++;
            send(C_START, {31'd0, lp});
            return;
        end
        g = (m_dwell == 0) ? 1 : int'(m_dwell);
        v = longint'(m_freq);
        push(m_freq, 1'b1, 1'b0, 0);
        k = 1;
        for (int i = 0; i < 200; i++) begin
            if (lp && k >= nvals) break;
            if (lp && v == longint'(m_stop)) nx = longint'(m_freq);
            else if (v + longint'(m_step) >= longint'(m_stop)) nx = longint'(m_stop);
            else nx = v + longint'(m_step);
            dn = !lp && (nx == longint'(m_stop));
            push(32'(nx), 1'b1, dn, g);
            k++;
            v = nx;
            if (dn) break;
        end
        target_g = pops + k;
        send(C_START, {31'd0, lp});
    endtask

    task automatic m_abort();
        push(m_freq, 1'b0, 1'b0, 0);
        send(C_ABORT, 32'd0);
    endtask

    task automatic chk_defaults(input string tag);
        chk({tag, "_freq"},  freq_ctrl,   D_FREQ);
        chk({tag, "_phase"}, phase_ctrl,  D_PHASE);
        chk({tag, "_wave"},  wave_select, D_WAVE);
        chk({tag, "_ready"}, cmd_ready,   1'b0);
        chk({tag, "_busy"},  busy,        1'b0);
        chk({tag, "_cfg"},   cfg_update,  1'b0);
        chk({tag, "_done"},  sweep_done,  1'b0);
        chk({tag, "_err"},   cmd_err,     1'b0);
    endtask

    task automatic nonloop_sweep();
        m_start(1'b0, 0);
        wait_drain();
        @(negedge sys_clk); #1;
        chk("busy_after_done", busy, 1'b0);
    endtask

    initial begin
        logic [31:0] f, st, k, r;
        bit lp;

        #23;
        chk_defaults("reset");
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        #1 chk("ready_before_edge", cmd_ready, 1'b0);
        @(negedge sys_clk); #1;
        chk("ready_after_release", cmd_ready, 1'b1);

        // Two-edge apply latency on SET_FREQ.
        push(32'd85898, 1'b0, 1'b0, 0);
        m_freq = 32'd85898;
        send(C_FREQ, 32'd85898);
        chk("lat_edge1_cfg",  cfg_update, 1'b0);
        chk("lat_edge1_freq", freq_ctrl,  D_FREQ);
        @(posedge sys_clk); #1;
        chk("lat_edge2_cfg",  cfg_update, 1'b1);
        chk("lat_edge2_freq", freq_ctrl,  32'd85898);

        m_set(C_WAVE, 32'h3);           // not one-hot: rejected
        m_start(1'b0, 0);               // step still 0: rejected
        wait_drain();
        chk("wave_kept", wave_select, D_WAVE);

        // 1000..1300 by 100, dwell 3.
        m_set(C_FREQ, 1000); m_set(C_STOP, 1300); m_set(C_STEP, 100); m_set(C_DWELL, 3);
        wait_drain();
        nonloop_sweep();

        // Saturating end point, then the same in loop mode with abort.
        m_set(C_STOP, 1250);
        wait_drain();
        nonloop_sweep();
        m_start(1'b1, 6);
        wait_pops(target_g);
        m_abort();
        wait_drain();
        chk("abort_busy", busy, 1'b0);

        // stop == start is not a valid sweep.
        m_set(C_STOP, 1000);
        m_start(1'b0, 0);
        wait_drain();

        // Sum overflows 32 bits; dwell 0 behaves as one cycle per point.
        m_set(C_FREQ, 32'hFFFF_FF00); m_set(C_STOP, 32'hFFFF_FFFF);
        m_set(C_STEP, 32'h200); m_set(C_DWELL, 0);
        wait_drain();
        nonloop_sweep();

        // A SET issued during a sweep waits and is applied afterwards.
        m_set(C_FREQ, 500); m_set(C_STOP, 900); m_set(C_STEP, 150); m_set(C_DWELL, 2);
        wait_drain();
        m_start(1'b0, 0);
        m_set(C_FREQ, 777);
        wait_drain();

        // SET_PHASE held off during a sweep, ABORT taken, then phase applied.
        m_set(C_FREQ, 1000); m_set(C_STOP, 1300); m_set(C_STEP, 100); m_set(C_DWELL, 20);
        wait_drain();
        m_start(1'b1, 1);
        wait_pops(target_g);
        @(negedge sys_clk);
        cmd_valid = 1'b1; cmd_op = 3'(C_PHASE); cmd_data = 32'h2AB;
        repeat (4) begin
            @(negedge sys_clk); #1;
            chk("holdoff_ready", cmd_ready, 1'b0);
            chk("holdoff_phase", phase_ctrl, m_phase);
        end
        push(m_freq, 1'b0, 1'b0, 0);
        cmd_op = 3'(C_ABORT);
        #1 chk("abort_ready", cmd_ready, 1'b1);
        @(posedge sys_clk); #1;
        cmd_valid = 1'b0;
        m_set(C_PHASE, 32'h2AB);
        wait_drain();
        chk("phase_applied", phase_ctrl, 12'h2AB);

        // Randomized sweeps.
        repeat (8) begin
            f  = $urandom_range(0, 1 << 20);
            st = $urandom_range(1, 2000);
            k  = $urandom_range(1, 6);
            r  = $urandom_range(0, 1) ? 0 : $urandom % st;
            lp = 1'($urandom_range(0, 1));
            m_set(C_WAVE, $urandom % 16);
            m_set(C_FREQ, f); m_set(C_STOP, f + st * k + r); m_set(C_STEP, st);
            m_set(C_DWELL, lp ? $urandom_range(3, 5) : $urandom_range(0, 4));
            wait_drain();
            if (lp) begin
                m_start(1'b1, int'($urandom_range(2, k + 4)));
                wait_pops(target_g);
                m_abort();
                wait_drain();
            end else begin
                nonloop_sweep();
            end
        end

        // Reset in the middle of a looping sweep.
        m_set(C_FREQ, 2000); m_set(C_STOP, 9000); m_set(C_STEP, 100); m_set(C_DWELL, 3);
        wait_drain();
        m_start(1'b1, 20);
        wait_pops(target_g - 17);
        @(negedge sys_clk); #2;
        sys_rst_n = 1'b0;
        #1 chk_defaults("rst_mid");
        sb.delete();
        repeat (2) begin
            @(negedge sys_clk); #1;
            chk("rst_hold_cfg",  cfg_update, 1'b0);
            chk("rst_hold_done", sweep_done, 1'b0);
            chk("rst_hold_busy", busy,       1'b0);
        end
        m_freq = D_FREQ; m_phase = D_PHASE; m_wave = D_WAVE;
        m_stop = 32'hFFFF_FFFF; m_step = 0; m_dwell = 0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk); #1;
        chk("ready_after_rst2", cmd_ready, 1'b1);
        m_start(1'b0, 0);               // step cleared by reset: rejected
        m_set(C_STEP, 10000); m_set(C_STOP, 80000);
        wait_drain();
        nonloop_sweep();

        repeat (5) @(negedge sys_clk);
        #1;
        chk("sb_empty", sb.size(), 0);
        chk("err_pending", exp_errs, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
